seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//   Time-multiplexed driver for an NUM_DIG-digit common-anode 7-segment display.
//   Holds one 4-bit hex value per digit, written through a valid/ready port.
//   Scans the digits in turn through one shared hex-to-segment decoder.
//   Inserts dead-time between digits to prevent ghosting.
//   Sits between the CPU/user-logic write port and the board segment/anode pins.
// PARAMETERS
//   NUM_DIG  4      number of digits scanned (2..8)
//   DWELL    50000  iCLK cycles each digit is driven (>=2)
//   BLANK    16     iCLK cycles of all-off gap between digits (>=1)
// PORTS
//   iCLK          in   1        system clock
//   iRST_N        in   1        reset, asynchronous, active-low
//   iEN           in   1        1 = scanning enabled, 0 = display dark
//   iWR_VALID     in   1        write request
//   oWR_READY     out  1        write accepted when iWR_VALID & oWR_READY at posedge
//   iWR_ADDR      in   AW       digit index, AW = $clog2(NUM_DIG); 0 = rightmost
//   iWR_DATA      in   4        hex value for that digit
//   iBLANK_MASK   in   NUM_DIG  1 = force digit dark (sampled every cycle)
//   iLZ_SUPPRESS  in   1        1 = blank leading zeros
//   oSEG          out  7        segments, active-low, bit6..0 = g..a
//   oDIG_EN       out  NUM_DIG  anode enables, active-low, at most one low
//   oSCAN_IDX     out  AW       index of digit currently in DRIVE
// BEHAVIOUR
//   Reset (async, iRST_N=0):
//     - Outputs: oSEG=7'h7F, oDIG_EN=all 1, oSCAN_IDX=0, oWR_READY=1.
//     - Internal: digit regs=0, state=IDLE, cnt=0, pending write cleared.
//     - Effect is immediate, including mid-DRIVE.
//   FSM states:
//     - IDLE:  outputs dark. If iEN=1 -> DRIVE with idx=0, cnt=0.
//     - DRIVE: oDIG_EN[idx]=0 and oSEG=decode(digit[idx]), or 7'h7F if that digit is blanked.
//              Stays DWELL cycles (cnt 0..DWELL-1), then -> GAP.
//     - GAP:   all dark for BLANK cycles, then -> DRIVE with idx=idx+1.
//              idx wraps NUM_DIG-1 -> 0.
//     - iEN=0 in any state -> IDLE at next edge; outputs dark that same edge.
//   Output timing:
//     - oSEG and oDIG_EN are registered and change on the same edge.
//     - No cycle shows a new anode with old segments.
//   Full scan period = NUM_DIG*(DWELL+BLANK) cycles.
//   Blanking rule (digit i is dark when either holds):
//     - iBLANK_MASK[i]=1.
//     - iLZ_SUPPRESS=1, digits NUM_DIG-1..i are all 0, and i!=0 (digit 0 is never LZ-blanked).
//   Writes, normal case:
//     - A handshake updates digit[iWR_ADDR] at that edge.
//     - The new value is visible at the next DRIVE of that digit, or at the next edge if that digit is already in DRIVE and no tear is possible.
//   Writes, collision with the digit in DRIVE:
//     - Capture the write into a pending reg at the handshake; oWR_READY=0 from the next cycle.
//     - Commit on the first GAP cycle; oWR_READY returns to 1 the cycle after commit.
//     - The value shown during the current DWELL is unchanged (no tearing).
//   Out-of-range address (iWR_ADDR>=NUM_DIG): handshake completes, data dropped.
//   Back-to-back writes to different, non-driven digits: one per cycle, oWR_READY stays 1.
//   Reset during a pending write discards it.
// STRUCTURE
//   - Shared include seg7_defs.vh: state encodings (IDLE/DRIVE/GAP), SEG_OFF=7'h7F, DIG_OFF, segment bit order.
//   - One instance of the existing SEG7_LUT (combinational, fed by a digit[idx] mux). Its output is registered here.
//   - Dwell/gap counter width = $clog2(max(DWELL,BLANK)).
// TESTING (NUM_DIG=4, DWELL=4, BLANK=2 unless stated)
//   1 Reset, then iEN=1: oDIG_EN=4'b1110 and oSEG=7'b1000000 (digit 0 = 0) for 4 cycles.
//     Then 2 cycles of 4'b1111 / 7'h7F, then 4'b1101. Period = 24 cycles.
//   2 Write A->digit2, B->digit0 back-to-back, no wait states.
//     Expect oSEG=7'b0001000 when oDIG_EN=4'b1011, and oSEG=7'b0000011 when 4'b1110.
//   3 Digits {0,0,5,0}, iLZ_SUPPRESS=1: digits 3,2 dark (7'h7F with anode low).
//     Digit1=7'b0010010, digit0=7'b1000000. All four dark digits 0 still show digit0.
//   4 Write 9 to the digit in DRIVE at its cnt=1:
//     - oWR_READY=0 next cycle; old segments held through cnt=3.
//     - Commit on GAP; 7'b0011000 at the next visit; oWR_READY back to 1.
//   5 Deassert iRST_N mid-DRIVE with a pending write:
//     - Outputs go dark asynchronously; after release all digits read 0 and oWR_READY=1.
//     - Also: iEN=0 mid-DRIVE -> dark next edge, then restart at idx 0.
//   6 iBLANK_MASK=4'b0100 plus write to iWR_ADDR=3 with NUM_DIG=3 (AW=2):
//     - Digit2 dark; addr-3 write is accepted and ignored.

Source files
------------

// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_scan_ctrl_pkg: shared scan states and constants for the 7-segment scan controller
package seg7_scan_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, GAP = 2'd2} state_t;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/seg7_scan_ctrl_lut.sv
// seg7_scan_ctrl_lut: hex digit to active-low 7-segment pattern, bit6..0 = g..a
module seg7_scan_ctrl_lut (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_comb
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0011000;
            4'ha: seg = 7'b0001000;
            4'hb: seg = 7'b0000011;
            4'hc: seg = 7'b1000110;
            4'hd: seg = 7'b0100001;
            4'he: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed common-anode 7-segment driver with dead-time and tear-free writes
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIG = 4,
    parameter int DWELL   = 50000,
    parameter int BLANK   = 16,
    localparam int AW     = $clog2(NUM_DIG)
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iEN,
    input  logic               iWR_VALID,
    output logic               oWR_READY,
    input  logic [AW-1:0]      iWR_ADDR,
    input  logic [3:0]         iWR_DATA,
    input  logic [NUM_DIG-1:0] iBLANK_MASK,
    input  logic               iLZ_SUPPRESS,
    output logic [6:0]         oSEG,
    output logic [NUM_DIG-1:0] oDIG_EN,
    output logic [AW-1:0]      oSCAN_IDX
);
    localparam int CW = $clog2(max2(DWELL, BLANK));

    state_t                  state, nstate;
    logic [AW-1:0]           idx, nidx, pend_addr;
    logic [CW-1:0]           cnt, ncnt;
    logic [NUM_DIG-1:0][3:0] digit;
    logic [3:0]              pend_data;
    logic [6:0]              seg_q, lut_seg;
    logic [NUM_DIG-1:0]      dig_q, lz_dark, dark;
    logic                    pend_v, last, n_drive, fire, in_rng, collide, commit, zero_run;

    always_comb begin
        last   = (state == DRIVE) ? (cnt == CW'(DWELL - 1)) : (cnt == CW'(BLANK - 1));
        nstate = !iEN ? IDLE : (state == IDLE) ? DRIVE : !last ? state : (state == DRIVE) ? GAP : DRIVE;
        ncnt   = (!iEN || state == IDLE || last) ? '0 : cnt + 1'b1;
        nidx   = (!iEN || state == IDLE) ? '0 :
                 (state == GAP && last) ? ((idx == AW'(NUM_DIG - 1)) ? '0 : idx + 1'b1) : idx;
    end

    // Outputs are registered from the next-cycle view, so "the digit in DRIVE" means nidx under nstate.
    assign n_drive   = nstate == DRIVE;
    assign fire      = iWR_VALID && !pend_v;
    assign in_rng    = {1'b0, iWR_ADDR} < (AW + 1)'(NUM_DIG);
    assign collide   = n_drive && iWR_ADDR == nidx;
    assign commit    = pend_v && state != DRIVE && !(n_drive && pend_addr == nidx);
    assign oWR_READY = !pend_v;

    always_comb begin
        zero_run = iLZ_SUPPRESS;
        lz_dark  = '0;
        for (int i = NUM_DIG - 1; i > 0; i--) begin
            zero_run   = zero_run && digit[i] == 4'd0;
            lz_dark[i] = zero_run;
        end
    end

    assign dark = lz_dark | iBLANK_MASK;

    seg7_scan_ctrl_lut u_lut (
        .hex (digit[nidx]),
        .seg (lut_seg)
    );

    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            digit     <= '0;
            pend_v    <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            seg_q     <= SEG_OFF;
            dig_q     <= '1;
        end else begin
            state <= nstate;
            idx   <= nidx;
            cnt   <= ncnt;
            seg_q <= (n_drive && !dark[nidx]) ? lut_seg : SEG_OFF;
            dig_q <= n_drive ? ~(NUM_DIG'(1) << nidx) : '1;
            if (fire && in_rng && !collide)
                digit[iWR_ADDR] <= iWR_DATA;
            if (commit)
                digit[pend_addr] <= pend_data;
            if (fire && in_rng && collide) begin
                pend_v    <= 1'b1;
                pend_addr <= iWR_ADDR;
                pend_data <= iWR_DATA;
            end else if (commit)
                pend_v <= 1'b0;
        end

    assign oSEG      = seg_q;
    assign oDIG_EN   = dig_q;
    assign oSCAN_IDX = idx;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed scoreboard bench for seg7_scan_ctrl (4-digit and 3-digit instances)
module tb_seg7_scan_ctrl;
    typedef struct {
        logic [3:0] dig;
        logic [6:0] seg;
        bit         d3;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, wv = 1'b0, lz = 1'b0;
    logic [1:0] wa = '0;
    logic [3:0] wd = '0, mask = '0;
    logic [6:0] seg;
    logic [3:0] dig;
    logic [1:0] idx;
    logic       rdy;

    logic       en3 = 1'b0, wv3 = 1'b0, lz3 = 1'b0;
    logic [1:0] wa3 = '0;
    logic [3:0] wd3 = '0;
    logic [2:0] mask3 = '0;
    logic [6:0] seg3;
    logic [2:0] dig3;
    logic [1:0] idx3;
    logic       rdy3;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.NUM_DIG(4), .DWELL(4), .BLANK(2)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iEN(en), .iWR_VALID(wv), .oWR_READY(rdy),
        .iWR_ADDR(wa), .iWR_DATA(wd), .iBLANK_MASK(mask), .iLZ_SUPPRESS(lz),
        .oSEG(seg), .oDIG_EN(dig), .oSCAN_IDX(idx)
    );

    seg7_scan_ctrl #(.NUM_DIG(3), .DWELL(4), .BLANK(2)) dut3 (
        .iCLK(clk), .iRST_N(rst_n), .iEN(en3), .iWR_VALID(wv3), .oWR_READY(rdy3),
        .iWR_ADDR(wa3), .iWR_DATA(wd3), .iBLANK_MASK(mask3), .iLZ_SUPPRESS(lz3),
        .oSEG(seg3), .oDIG_EN(dig3), .oSCAN_IDX(idx3)
    );

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic void push(input string tag, input logic [3:0] d, input logic [6:0] s, input bit d3);
        exp_t e;
        e.dig = d;
        e.seg = s;
        e.d3  = d3;
        e.tag = tag;
        sb.push_back(e);
    endfunction

    // Waits (bounded) for the expected anode pattern, then checks the segments shown with it.
    task automatic expect_next();
        exp_t       e;
        bit         found;
        logic [3:0] od;
        e     = sb.pop_front();
        found = 1'b0;
        for (int c = 0; c < 80 && !found; c++) begin
            @(negedge clk);
            od    = e.d3 ? {1'b1, dig3} : dig;
            found = (od == e.dig);
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: anode pattern %0h never observed", e.tag, e.dig);
        end else
            chk(e.tag, e.d3 ? {25'd0, seg3} : {25'd0, seg}, {25'd0, e.seg});
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        chk("wr_ready", {31'd0, rdy}, 32'd1);
        wv = 1'b1;
        wa = a;
        wd = d;
        @(negedge clk);
        wv = 1'b0;
    endtask

    task automatic wr3(input logic [1:0] a, input logic [3:0] d);
        chk("wr3_ready", {31'd0, rdy3}, 32'd1);
        wv3 = 1'b1;
        wa3 = a;
        wd3 = d;
        @(negedge clk);
        wv3 = 1'b0;
    endtask

    initial begin
        exp_t       e;
        int         r;
        logic [3:0] one_hot;
        repeat (2) @(negedge clk);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dig", {28'd0, dig}, 32'hF);
        chk("rst_idx", {30'd0, idx}, 32'd0);
        chk("rst_rdy", {31'd0, rdy}, 32'd1);
        chk("rst3_dig", {29'd0, dig3}, 32'h7);
        rst_n = 1'b1;

        // Free-running scan of an all-zero display: 4 drive, 2 gap, 24-cycle period.
        @(negedge clk);
        en = 1'b1;
        for (int k = 0; k < 25; k++) begin
            r       = (k % 24) % 6;
            one_hot = 4'b0001 << ((k % 24) / 6);
            push("scan", (r < 4) ? ~one_hot : 4'hF, (r < 4) ? 7'h40 : 7'h7F, 1'b0);
        end
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            chk("scan_dig", {28'd0, dig}, {28'd0, e.dig});
            chk("scan_seg", {25'd0, seg}, {25'd0, e.seg});
            if ((k % 24) % 6 < 4)
                chk("scan_idx", {30'd0, idx}, (k % 24) / 6);
        end

        // Enable drop mid-DRIVE goes dark next edge, restart begins at digit 0.
        en = 1'b0;
        @(negedge clk);
        chk("en0_dig", {28'd0, dig}, 32'hF);
        chk("en0_seg", {25'd0, seg}, 32'h7F);
        chk("en0_idx", {30'd0, idx}, 32'd0);
        en = 1'b1;
        @(negedge clk);
        chk("restart_dig", {28'd0, dig}, 32'hE);
        en = 1'b0;
        @(negedge clk);

        // Back-to-back writes to non-driven digits.
        wr(2'd2, 4'hA);
        wr(2'd0, 4'hB);
        chk("b2b_ready", {31'd0, rdy}, 32'd1);
        en = 1'b1;
        push("d0_b", 4'b1110, 7'b0000011, 1'b0);
        push("d1_0", 4'b1101, 7'b1000000, 1'b0);
        push("d2_a", 4'b1011, 7'b0001000, 1'b0);
        push("d3_0", 4'b0111, 7'b1000000, 1'b0);
        repeat (4) expect_next();

        // Leading-zero suppression on {0,0,5,0}, then all zeros.
        en = 1'b0;
        @(negedge clk);
        wr(2'd2, 4'h0);
        wr(2'd1, 4'h5);
        wr(2'd0, 4'h0);
        lz = 1'b1;
        en = 1'b1;
        push("lz_d0", 4'b1110, 7'b1000000, 1'b0);
        push("lz_d1", 4'b1101, 7'b0010010, 1'b0);
        push("lz_d2", 4'b1011, 7'h7F, 1'b0);
        push("lz_d3", 4'b0111, 7'h7F, 1'b0);
        repeat (4) expect_next();
        en = 1'b0;
        @(negedge clk);
        wr(2'd1, 4'h0);
        en = 1'b1;
        push("lz0_d0", 4'b1110, 7'b1000000, 1'b0);
        push("lz0_d1", 4'b1101, 7'h7F, 1'b0);
        push("lz0_d2", 4'b1011, 7'h7F, 1'b0);
        repeat (3) expect_next();

        // Write to the digit in DRIVE at cnt=1: deferred to the gap, no tearing.
        en = 1'b0;
        @(negedge clk);
        lz = 1'b0;
        en = 1'b1;
        @(negedge clk);
        chk("col_c0_dig", {28'd0, dig}, 32'hE);
        @(negedge clk);
        wv = 1'b1;
        wa = 2'd0;
        wd = 4'h9;
        @(negedge clk);
        wv = 1'b0;
        chk("col_c2_rdy", {31'd0, rdy}, 32'd0);
        chk("col_c2_seg", {25'd0, seg}, 32'h40);
        chk("col_c2_dig", {28'd0, dig}, 32'hE);
        @(negedge clk);
        chk("col_c3_seg", {25'd0, seg}, 32'h40);
        chk("col_c3_rdy", {31'd0, rdy}, 32'd0);
        @(negedge clk);
        chk("col_g0_dig", {28'd0, dig}, 32'hF);
        chk("col_g0_rdy", {31'd0, rdy}, 32'd0);
        @(negedge clk);
        chk("col_g1_rdy", {31'd0, rdy}, 32'd1);
        push("col_d1", 4'b1101, 7'b1000000, 1'b0);
        push("col_d0_9", 4'b1110, 7'b0011000, 1'b0);
        repeat (2) expect_next();

        // Async reset mid-DRIVE with a pending write discards everything.
        push("pre_rst_d1", 4'b1101, 7'b1000000, 1'b0);
        expect_next();
        wv = 1'b1;
        wa = 2'd1;
        wd = 4'h7;
        @(negedge clk);
        wv = 1'b0;
        chk("pend_rdy", {31'd0, rdy}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dig", {28'd0, dig}, 32'hF);
        chk("arst_seg", {25'd0, seg}, 32'h7F);
        chk("arst_rdy", {31'd0, rdy}, 32'd1);
        chk("arst_idx", {30'd0, idx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push("post_d0", 4'b1110, 7'b1000000, 1'b0);
        push("post_d1", 4'b1101, 7'b1000000, 1'b0);
        push("post_d2", 4'b1011, 7'b1000000, 1'b0);
        push("post_d3", 4'b0111, 7'b1000000, 1'b0);
        repeat (4) expect_next();

        // 3-digit instance: blank mask on digit 2 and an out-of-range address write.
        wr3(2'd1, 4'h3);
        wr3(2'd3, 4'h8);
        chk("oor_ready", {31'd0, rdy3}, 32'd1);
        mask3 = 3'b100;
        en3   = 1'b1;
        push("n3_d0", 4'b1110, 7'b1000000, 1'b1);
        push("n3_d1", 4'b1101, 7'b0110000, 1'b1);
        push("n3_d2_mask", 4'b1011, 7'h7F, 1'b1);
        push("n3_wrap_d0", 4'b1110, 7'b1000000, 1'b1);
        repeat (4) expect_next();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
